// File: rtl/digit_overlay_ctrl.sv
// digit_overlay_ctrl: renders a NUM_DIGITS-wide BCD number from an 8x12 font ROM
// as a 1-bit pixel stream aligned with the VGA raster. The displayed value is
// double-buffered so it changes only at frame start.
module digit_overlay_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int ORIGIN_X   = 16,
    parameter int ORIGIN_Y   = 16,
    parameter bit LZ_BLANK   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [9:0]              pix_x,
    input  logic [9:0]              pix_y,
    input  logic                    video_on,
    input  logic                    frame_start,
    input  logic                    value_wr,
    input  logic [4*NUM_DIGITS-1:0] value_bcd,
    output logic                    value_pending,
    output logic [3:0]              rom_digit,
    output logic [3:0]              rom_row,
    input  logic [7:0]              rom_bitmap,
    output logic                    pixel_on
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [9:0] START_X    = 10'(ORIGIN_X - 1);
    localparam logic [9:0] BAND_Y     = 10'(ORIGIN_Y);
    localparam logic [2:0] LAST_DIG   = 3'(NUM_DIGITS - 1);
    localparam logic [3:0] BLANK_CODE = 4'hF;

    state_t state;
    state_t state_next;

    logic [4*NUM_DIGITS-1:0] shadow;
    logic [4*NUM_DIGITS-1:0] pending_val;

    logic [9:0] ydiff;
    logic       in_band;
    logic       start_run;
    logic       at_last_bit;
    logic [2:0] next_idx;

    logic [3:0] digit_code [0:7];
    logic       all_zero;
    logic [3:0] nib;

    logic [2:0] bit_cnt;
    logic [2:0] dig_cnt;
    logic [7:0] shreg;

    logic       pixel_on_d;
    logic [3:0] rom_digit_d;
    logic [3:0] rom_row_d;
    logic [2:0] bit_cnt_d;
    logic [2:0] dig_cnt_d;
    logic [7:0] shreg_d;

    // Band detection: unsigned wrap makes scanlines above the band look huge.
    always_comb begin
        ydiff       = pix_y - BAND_Y;
        in_band     = (ydiff < 10'd12);
        start_run   = video_on && in_band && (pix_x == START_X);
        at_last_bit = (bit_cnt == 3'd7);
        next_idx    = dig_cnt + 3'd1;
    end

    // Per-digit ROM code from the shadow value, with leading zeros mapped to blank.
    always_comb begin
        all_zero = 1'b1;
        nib      = 4'd0;
        for (int k = 0; k < 8; k++) begin
            digit_code[k] = BLANK_CODE;
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            nib      = shadow[4*(NUM_DIGITS-1-k) +: 4];
            all_zero = all_zero && (nib == 4'd0);
            if (LZ_BLANK && all_zero && (k < NUM_DIGITS - 1)) begin
                digit_code[k] = BLANK_CODE;
            end else begin
                digit_code[k] = nib;
            end
        end
    end

    // Value double buffer: writes park in pending until a frame start commits them.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow        <= '0;
            pending_val   <= '0;
            value_pending <= 1'b0;
        end else if (frame_start && value_wr) begin
            shadow        <= value_bcd;
            pending_val   <= value_bcd;
            value_pending <= 1'b0;
        end else if (frame_start && value_pending) begin
            shadow        <= pending_val;
            value_pending <= 1'b0;
        end else if (value_wr) begin
            pending_val   <= value_bcd;
            value_pending <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start one pixel before the glyph area, stop after the last digit or on blanking.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_run) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!video_on) begin
                    state_next = IDLE;
                end else if (at_last_bit && (dig_cnt == LAST_DIG)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output and datapath next values: ROM fetch one pixel ahead, then serialise the glyph row MSB first.
    always_comb begin
        pixel_on_d  = pixel_on;
        rom_digit_d = rom_digit;
        rom_row_d   = rom_row;
        bit_cnt_d   = bit_cnt;
        dig_cnt_d   = dig_cnt;
        shreg_d     = shreg;
        case (state)
            IDLE: begin
                pixel_on_d = 1'b0;
                if (start_run) begin
                    rom_digit_d = digit_code[0];
                    rom_row_d   = ydiff[3:0];
                    dig_cnt_d   = 3'd0;
                    bit_cnt_d   = 3'd0;
                end
            end
            RUN: begin
                if (!video_on) begin
                    pixel_on_d  = 1'b0;
                    rom_digit_d = BLANK_CODE;
                    bit_cnt_d   = 3'd0;
                    dig_cnt_d   = 3'd0;
                end else begin
                    if (bit_cnt == 3'd0) begin
                        pixel_on_d = rom_bitmap[7];
                        shreg_d    = {rom_bitmap[6:0], 1'b0};
                    end else begin
                        pixel_on_d = shreg[7];
                        shreg_d    = {shreg[6:0], 1'b0};
                    end
                    bit_cnt_d = bit_cnt + 3'd1;
                    if (at_last_bit) begin
                        if (dig_cnt < LAST_DIG) begin
                            rom_digit_d = digit_code[next_idx];
                            dig_cnt_d   = next_idx;
                        end else begin
                            rom_digit_d = BLANK_CODE;
                            dig_cnt_d   = 3'd0;
                        end
                    end
                end
            end
            default: begin
                pixel_on_d  = 1'b0;
                rom_digit_d = BLANK_CODE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_on  <= 1'b0;
            rom_digit <= BLANK_CODE;
            rom_row   <= 4'd0;
            bit_cnt   <= 3'd0;
            dig_cnt   <= 3'd0;
            shreg     <= 8'd0;
        end else begin
            pixel_on  <= pixel_on_d;
            rom_digit <= rom_digit_d;
            rom_row   <= rom_row_d;
            bit_cnt   <= bit_cnt_d;
            dig_cnt   <= dig_cnt_d;
            shreg     <= shreg_d;
        end
    end

endmodule

// File: doc/digit_overlay_ctrl.md
Name: digit_overlay_ctrl

Overview:
- Sequences the 8x12 digit font ROM, driving `rom_digit`/`rom_row` and consuming `rom_bitmap`, to render an NUM_DIGITS-wide BCD number on the VGA raster.
- Serialises each 8-bit glyph row into a 1-bit `pixel_on` stream, aligned with the pixel stream from the VGA timing generator.
- Double-buffers the displayed value so updates take effect only at frame start, which prevents tearing.

Parameters:
- NUM_DIGITS, 4, number of digit cells rendered left to right (1..8).
- ORIGIN_X, 16, pixel column of the left edge of digit 0 (must be >= 1).
- ORIGIN_Y, 16, scanline of glyph row 0.
- LZ_BLANK, 1, 1 = leading zeros blanked (the last digit is never blanked); 0 = all digits shown.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- pix_x  in  10  current pixel column from the timing generator.
- pix_y  in  10  current scanline from the timing generator.
- video_on  in  1  active-video qualifier.
- frame_start  in  1  one-cycle pulse at the start of each frame.
- value_wr  in  1  write strobe for value_bcd.
- value_bcd  in  4*NUM_DIGITS  BCD value; the top nibble is digit 0 (leftmost).
- value_pending  out  1  a written value is waiting for frame_start.
- rom_digit  out  4  font ROM digit select (registered).
- rom_row  out  4  font ROM row select, 0..11 (registered).
- rom_bitmap  in  8  font ROM row data; combinational from rom_digit/rom_row, MSB = leftmost pixel.
- pixel_on  out  1  glyph pixel; lags pix_x by 1 cycle.

Behaviour:
- Reset values:
  - pixel_on=0, rom_digit=4'hF (blank code; the ROM returns 0 for codes >9), rom_row=0, value_pending=0.
  - Shadow and pending value = 0, FSM=IDLE, bit_cnt=0, dig_cnt=0.
- Value buffering:
  - value_wr loads the pending register and sets value_pending.
  - On frame_start with value_pending=1: shadow <= pending, value_pending <= 0.
  - value_wr and frame_start in the same cycle: shadow <= value_bcd directly; value_pending <= 0.
  - A second value_wr before frame_start overwrites pending; last write wins.
  - The shadow never changes except on frame_start.
- In band: pix_y in [ORIGIN_Y, ORIGIN_Y+11]. row = pix_y - ORIGIN_Y, truncated to 4 bits.
- Blank mask: computed from the shadow. With LZ_BLANK=1, digit k is blank iff every nibble 0..k is 0 and k < NUM_DIGITS-1. Blank digits drive rom_digit=4'hF.
- FSM IDLE:
  - pixel_on <= 0.
  - When video_on, in band and pix_x == ORIGIN_X-1: rom_digit <= digit 0 (or F if blank), rom_row <= row, dig_cnt <= 0, bit_cnt <= 0, go to RUN.
- FSM RUN (each cycle, the pixel at pix_x = ORIGIN_X + 8*dig_cnt + bit_cnt):
  - bit_cnt==0: pixel_on <= rom_bitmap[7]; shreg <= {rom_bitmap[6:0],0}.
  - bit_cnt 1..7: pixel_on <= shreg[7]; shreg shifts left by 1.
  - bit_cnt==7 and dig_cnt < NUM_DIGITS-1: rom_digit <= next digit (or F), so its bitmap is ready on the next bit_cnt==0. bit_cnt wraps to 0; dig_cnt += 1.
  - bit_cnt==7 and dig_cnt == NUM_DIGITS-1: go to IDLE; rom_digit <= F.
- RUN abort: video_on=0 while in RUN forces IDLE next cycle, pixel_on <= 0, counters cleared. No resume on that line.
- Output timing: pixel_on is registered, one cycle after its pix_x. Total rendered width is 8*NUM_DIGITS pixels per band line.
- Boundaries:
  - Rows 11 of every glyph are 0 per the font, so a one-row gap appears naturally.
  - pix_y outside the band never enters RUN.
  - rst asserted mid-RUN returns all state to reset values on the next edge.
  - frame_start during RUN updates the shadow but does not alter the rom_digit already issued; later fetches on that line use the new shadow.

Test Plan:
- Reset, then write value_bcd=16'h0123 without frame_start → value_pending=1. Band line 0 still renders the shadow (0000 → blanks plus a final "0").
- value_wr 16'h0123 then frame_start; scan row 0 (pix_y=16) → digit 0 blank (pixel_on=0 for x=16..23), then row bytes 00011000, 01111110, 01111110 serialised for x=24..47, each one cycle after pix_x.
- LZ_BLANK=0, value 16'h0000, row 0 → pattern 00111100 repeated 4 times across x=16..47.
- video_on dropped at x=30 during row 3 → pixel_on=0 from the next cycle; FSM returns to IDLE and stays there until the next line's x=15.
- value_wr 16'h9999 in the same cycle as frame_start → shadow=9999 immediately and value_pending=0. Row 5 shows 01111111 ×4.
- rst pulse at pix_x=35 in band → next cycle pixel_on=0, rom_digit=F, value_pending=0, shadow=0.
